// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the register file write port
//
// Optional feature macro: WB_ARB_RR_EN
//   undefined : req1 has fixed priority; req0 is force-granted after waiting STARVE_LIMIT cycles
//   defined   : round-robin between the requesters; the starvation guard is removed
//
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   req0_valid_i/ready_o/addr_i/data_i  ALU writeback request (valid/ready handshake)
//   req1_valid_i/ready_o/addr_i/data_i  load writeback request (valid/ready handshake)
//   rf_we_o, rf_addr_o, rf_data_o    registered register-file write command
//   pend_mask_o                      registers with a write requested or in flight
//   conflict_cnt_o                   saturating count of cycles with both requests valid

module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req0_addr_i,
    input  logic [DATA_WIDTH-1:0]   req0_data_i,
    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req1_addr_i,
    input  logic [DATA_WIDTH-1:0]   req1_data_i,
    output logic                    rf_we_o,
    output logic [ADDR_WIDTH-1:0]   rf_addr_o,
    output logic [DATA_WIDTH-1:0]   rf_data_o,
    output logic [2**ADDR_WIDTH-1:0] pend_mask_o,
    output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic grant0;
    logic grant1;
    logic bothValid;
    logic sameAddr;

    assign bothValid = req0_valid_i & req1_valid_i;
    // The load must land before the ALU value so the younger ALU result is the one left in the register.
    assign sameAddr  = bothValid && (req0_addr_i == req1_addr_i) && (req0_addr_i != '0);

`ifdef WB_ARB_RR_EN
    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rrPrio_t;

    // Requester that wins the next tie; flips to the other side on every grant.
    rrPrio_t rrPrio;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rrPrio <= PRIO_REQ1;
        end else if (grant0) begin
            rrPrio <= PRIO_REQ1;
        end else if (grant1) begin
            rrPrio <= PRIO_REQ0;
        end
    end
`else
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    // Cycles req0 has been valid and passed over; saturates at the limit.
    logic [STARVE_W-1:0] starveCnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starveCnt <= '0;
        end else if (!req0_valid_i || grant0) begin
            starveCnt <= '0;
        end else if (starveCnt < STARVE_W'(STARVE_LIMIT)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_ni) begin
            if (bothValid) begin
                if (sameAddr) begin
                    grant1 = 1'b1;
`ifdef WB_ARB_RR_EN
                end else if (rrPrio == PRIO_REQ0) begin
                    grant0 = 1'b1;
`else
                end else if (starveCnt >= STARVE_W'(STARVE_LIMIT)) begin
                    grant0 = 1'b1;
`endif
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Grants to x0 are consumed without a write; address/data then hold like an idle cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
        end else begin
            rf_we_o <= 1'b0;
            if (grant1) begin
                if (req1_addr_i != '0) begin
                    rf_we_o   <= 1'b1;
                    rf_addr_o <= req1_addr_i;
                    rf_data_o <= req1_data_i;
                end
            end else if (grant0) begin
                if (req0_addr_i != '0) begin
                    rf_we_o   <= 1'b1;
                    rf_addr_o <= req0_addr_i;
                    rf_data_o <= req0_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conflict_cnt_o <= '0;
        end else if (bothValid && (conflict_cnt_o != '1)) begin
            conflict_cnt_o <= conflict_cnt_o + 1'b1;
        end
    end

    // Bit 0 is never pending because x0 is never written.
    always_comb begin
        pend_mask_o = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if ((req0_valid_i && (req0_addr_i == ADDR_WIDTH'(k))) ||
                (req1_valid_i && (req1_addr_i == ADDR_WIDTH'(k))) ||
                (rf_we_o && (rf_addr_o == ADDR_WIDTH'(k)))) begin
                pend_mask_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU/execute result) and req1 (load/memory result).
- Arbitrates with valid/ready handshakes and drives a registered write command (we/addr/data) straight into the register file write port.
- Exports a pending-write mask for the hazard/stall unit and a saturating conflict counter for performance debug.

Parameters:
- ADDR_WIDTH, 5, register address width; register file depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register word width.
- STARVE_LIMIT, 4, consecutive cycles req0 may wait while valid before it is force-granted.
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk_i  in  1  clock; all state changes on posedge.
- rst_ni  in  1  synchronous active-low reset.
- req0_valid_i  in  1  ALU write request.
- req0_ready_o  out  1  ALU request accepted this cycle.
- req0_addr_i  in  ADDR_WIDTH  ALU destination register.
- req0_data_i  in  DATA_WIDTH  ALU result.
- req1_valid_i  in  1  load write request.
- req1_ready_o  out  1  load request accepted this cycle.
- req1_addr_i  in  ADDR_WIDTH  load destination register.
- req1_data_i  in  DATA_WIDTH  load data.
- rf_we_o  out  1  register file write enable (registered).
- rf_addr_o  out  ADDR_WIDTH  register file write address (registered).
- rf_data_o  out  DATA_WIDTH  register file write data (registered).
- pend_mask_o  out  2**ADDR_WIDTH  registers with a write not yet committed (combinational).
- conflict_cnt_o  out  CNT_WIDTH  saturating count of cycles with both requests valid.

Behaviour:
- Reset (rst_ni=0 at posedge): rf_we_o=0, rf_addr_o=0, rf_data_o=0, conflict_cnt_o=0, starvation counter=0, RR pointer=req1. req*_ready_o=0 while rst_ni=0. Reset mid-handshake drops the request; the requester re-presents it.
- Handshake: a transfer occurs when valid&ready are both high at a posedge. Requester holds addr/data stable while valid&!ready. ready_o is combinational from the valids and arbiter state; at most one ready is high per cycle.
- Latency: request accepted at edge N gives rf_we_o=1 with its addr/data during cycle N+1; the register file commits at edge N+1. One write per cycle max; back-to-back grants give continuous rf_we_o.
- rf_we_o deasserts the cycle after a cycle with no grant. rf_addr_o/rf_data_o hold their last values when idle.
- Address 0: the request is accepted normally, but rf_we_o stays 0 for it (x0 is never written).
- Only one valid: it is granted immediately.
- Both valid, default fixed priority: req1 wins.
- Starvation counter counts cycles with req0 valid and not granted; it clears on req0 grant or when req0 is not valid. When the count reaches STARVE_LIMIT, req0 is granted that cycle.
- Same-address collision (both valid, equal nonzero addr): req1 is always granted first, overriding starvation and round-robin. req0 follows in the next cycle, so the ALU value is the final one.
- pend_mask_o: bit k=1 if (req0_valid_i & req0_addr_i==k) or (req1_valid_i & req1_addr_i==k) or (rf_we_o & rf_addr_o==k). Bit 0 is always 0.
- conflict_cnt_o increments on each posedge with both valids high. It saturates at all-ones and does not wrap.

Optional Feature:
- Macro WB_ARB_RR_EN.
- Defined: round-robin replaces fixed priority. When both are valid and addresses differ, the requester not granted most recently wins. The pointer updates on every grant. The same-address rule still forces req1 first. Starvation logic is removed (round-robin bounds waiting to 1 cycle).
- Undefined: fixed priority plus STARVE_LIMIT guard, as described in Behaviour.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with both valids high -> readies 0, rf_we_o=0, conflict_cnt_o=0.
- Single ALU write: req0 addr=5, data=0xDEADBEEF at edge N -> req0_ready_o=1 in cycle N; rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF in cycle N+1; pend_mask_o[5]=1 in cycles N and N+1, then 0.
- x0 drop: req1 addr=0, data=0x1234 -> accepted, rf_we_o stays 0, pend_mask_o[0]=0 throughout.
- Same-address collision: req0 addr=7 data=0xA, req1 addr=7 data=0xB, both valid -> cycle 1 rf_data_o=0xB, cycle 2 rf_data_o=0xA. conflict_cnt_o=1.
- Starvation (WB_ARB_RR_EN off): req1 streams to addr 3 continuously, req0 holds addr 9 -> req0 is granted on its 5th waiting cycle (STARVE_LIMIT=4). With WB_ARB_RR_EN on, grants alternate req1, req0, req1, ...
- Counter saturation: CNT_WIDTH=4, both valid with differing addresses for 20 cycles -> conflict_cnt_o stops at 15.
